// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : graphics_pkg
//  Description : Shared screen geometry, colours, job/state encodings and
//                pixel colour rule for the graphics draw engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package graphics_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = $clog2(SCREEN_W);
   localparam int Y_W      = $clog2(SCREEN_H);

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] BLUE  = 3'b001;
   localparam logic [2:0] GOLD  = 3'b110;
   localparam logic [2:0] GREEN = 3'b010;

   localparam int DEF_MONEY_X0    = 4;
   localparam int DEF_MONEY_Y0    = 4;
   localparam int DEF_BAR_MAX_W   = 64;
   localparam int DEF_BAR_H       = 8;
   localparam int DEF_MONEY_SHIFT = 2;
   localparam int DEF_SEL_X0      = 8;
   localparam int DEF_SEL_Y0      = 40;
   localparam int DEF_SEL_W       = 32;
   localparam int DEF_SEL_H       = 24;
   localparam int DEF_SEL_PITCH   = 36;
   localparam int DEF_NUM_ITEMS   = 4;
   localparam int DEF_UPG_X0      = 4;
   localparam int DEF_UPG_Y0      = 80;
   localparam int DEF_UPG_W       = 128;
   localparam int DEF_UPG_H       = 8;
   localparam int DEF_UPG_STEP    = 8;

   // Job index doubles as the bit position in the pending-request vector
   typedef enum logic [1:0] {
      JOB_ERASE = 2'd0,
      JOB_SEL   = 2'd1,
      JOB_UPG   = 2'd2,
      JOB_MONEY = 2'd3
   } job_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Colour of one pixel given its offset inside the job rectangle; fill is
   // the coloured column count for the bar jobs
   function automatic logic [2:0] pixel_colour(input job_t           job,
                                               input logic [X_W-1:0] col,
                                               input logic [Y_W-1:0] row,
                                               input logic [X_W-1:0] w,
                                               input logic [Y_W-1:0] h,
                                               input logic [X_W-1:0] fill);
      logic [2:0] c;
      c = BLACK;
      case (job)
         JOB_ERASE: c = BLACK;
         JOB_SEL: begin
            if ((col == '0) || (row == '0) ||
                (col == w - X_W'(1)) || (row == h - Y_W'(1)))
               c = WHITE;
            else
               c = BLUE;
         end
         JOB_UPG:   c = (col < fill) ? GREEN : BLACK;
         JOB_MONEY: c = (col < fill) ? GOLD  : BLACK;
         default:   c = BLACK;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/graphics_draw_engine_rect_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : rect_scanner
//  Description : Walks a rectangle in raster order, one pixel per clock,
//                reporting absolute position, offsets and the last pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_scanner
   import graphics_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [X_W-1:0] x0,
   input  logic [Y_W-1:0] y0,
   input  logic [X_W-1:0] w,
   input  logic [Y_W-1:0] h,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [X_W-1:0] col,
   output logic [Y_W-1:0] row,
   output logic           valid,
   output logic           last
);

   logic [X_W-1:0] base_x, width, cnt_col, use_x0, use_w;
   logic [Y_W-1:0] base_y, height, cnt_row, use_y0, use_h;
   logic           active;

   // First pixel is presented on the start cycle itself so it reaches the
   // output registers without an extra pipeline stage
   always_comb begin
      if (start) begin
         use_x0 = x0;
         use_y0 = y0;
         use_w  = w;
         use_h  = h;
         col    = '0;
         row    = '0;
         valid  = 1'b1;
      end else begin
         use_x0 = base_x;
         use_y0 = base_y;
         use_w  = width;
         use_h  = height;
         col    = cnt_col;
         row    = cnt_row;
         valid  = active;
      end
      x    = use_x0 + col;
      y    = use_y0 + row;
      last = valid && (col == use_w - X_W'(1)) && (row == use_h - Y_W'(1));
   end

   // Geometry capture and raster counter advance
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         base_x  <= '0;
         base_y  <= '0;
         width   <= '0;
         height  <= '0;
         cnt_col <= '0;
         cnt_row <= '0;
         active  <= 1'b0;
      end else begin
         if (start) begin
            base_x <= x0;
            base_y <= y0;
            width  <= w;
            height <= h;
         end
         if (valid) begin
            if (last) begin
               active  <= 1'b0;
               cnt_col <= '0;
               cnt_row <= '0;
            end else begin
               active <= 1'b1;
               if (col == use_w - X_W'(1)) begin
                  cnt_col <= '0;
                  cnt_row <= row + Y_W'(1);
               end else begin
                  cnt_col <= col + X_W'(1);
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/graphics_draw_engine.sv
`default_nettype none
// ============================================================================
//  Module      : graphics_draw_engine
//  Description : Buffers draw strobes as sticky pending requests, serves them
//                one at a time by priority and rasterises each job's
//                rectangle onto the VGA adapter plot interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module graphics_draw_engine
   import graphics_pkg::*;
#(
   parameter int MONEY_X0    = DEF_MONEY_X0,
   parameter int MONEY_Y0    = DEF_MONEY_Y0,
   parameter int BAR_MAX_W   = DEF_BAR_MAX_W,
   parameter int BAR_H       = DEF_BAR_H,
   parameter int MONEY_SHIFT = DEF_MONEY_SHIFT,
   parameter int SEL_X0      = DEF_SEL_X0,
   parameter int SEL_Y0      = DEF_SEL_Y0,
   parameter int SEL_W       = DEF_SEL_W,
   parameter int SEL_H       = DEF_SEL_H,
   parameter int SEL_PITCH   = DEF_SEL_PITCH,
   parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
   parameter int UPG_X0      = DEF_UPG_X0,
   parameter int UPG_Y0      = DEF_UPG_Y0,
   parameter int UPG_W       = DEF_UPG_W,
   parameter int UPG_H       = DEF_UPG_H,
   parameter int UPG_STEP    = DEF_UPG_STEP
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           drawMoney,
   input  logic           drawSelection,
   input  logic           drawUpgrade,
   input  logic           black,
   input  logic [15:0]    money,
   input  logic [1:0]     selIndex,
   input  logic [3:0]     upgradeLevel,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [2:0]     colour,
   output logic           plot,
   output logic           busy,
   output logic           done
);

   state_t         state, state_nx;
   job_t           job, job_nx;
   logic [3:0]     pend, req_set, req_clear;
   logic           start;
   logic [1:0]     sel_idx;
   logic [15:0]    money_shift;
   int             upg_width;
   logic [X_W-1:0] geo_x0, geo_w, geo_fill, fill_reg, fill_use;
   logic [Y_W-1:0] geo_y0, geo_h;
   logic [X_W-1:0] scan_x, scan_col;
   logic [Y_W-1:0] scan_y, scan_row;
   logic           scan_valid, scan_last;
   logic [2:0]     pix_colour;

   // Request decode; black alone never raises a request
   assign req_set = {drawMoney, drawUpgrade, drawSelection & ~black, drawSelection & black};

   assign busy = (state != ST_IDLE) | (|pend);

   // State and job registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         job   <= JOB_ERASE;
      end else begin
         state <= state_nx;
         job   <= job_nx;
      end
   end

   // Next state, launch priority and scanner start
   always_comb begin
      state_nx  = state;
      job_nx    = job;
      req_clear = 4'b0000;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pend[JOB_ERASE]) begin
               job_nx = JOB_ERASE;
               req_clear[JOB_ERASE] = 1'b1;
            end else if (pend[JOB_SEL]) begin
               job_nx = JOB_SEL;
               req_clear[JOB_SEL] = 1'b1;
            end else if (pend[JOB_UPG]) begin
               job_nx = JOB_UPG;
               req_clear[JOB_UPG] = 1'b1;
            end else if (pend[JOB_MONEY]) begin
               job_nx = JOB_MONEY;
               req_clear[JOB_MONEY] = 1'b1;
            end
            if (|pend) state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            start    = 1'b1;
            state_nx = ST_SCAN;
         end
         ST_SCAN: begin
            if (scan_last) state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Job rectangle and fill width from the live operands (sampled during LOAD)
   always_comb begin
      sel_idx = selIndex;
      if (int'(selIndex) >= NUM_ITEMS) sel_idx = 2'(NUM_ITEMS - 1);
      money_shift = money >> MONEY_SHIFT;
      upg_width   = int'(upgradeLevel) * UPG_STEP;
      geo_x0   = '0;
      geo_y0   = '0;
      geo_w    = '0;
      geo_h    = '0;
      geo_fill = '0;
      case (job)
         JOB_ERASE: begin
            geo_x0 = X_W'(SEL_X0);
            geo_y0 = Y_W'(SEL_Y0);
            geo_w  = X_W'(NUM_ITEMS * SEL_PITCH);
            geo_h  = Y_W'(SEL_H);
         end
         JOB_SEL: begin
            geo_x0 = X_W'(SEL_X0 + int'(sel_idx) * SEL_PITCH);
            geo_y0 = Y_W'(SEL_Y0);
            geo_w  = X_W'(SEL_W);
            geo_h  = Y_W'(SEL_H);
         end
         JOB_UPG: begin
            geo_x0   = X_W'(UPG_X0);
            geo_y0   = Y_W'(UPG_Y0);
            geo_w    = X_W'(UPG_W);
            geo_h    = Y_W'(UPG_H);
            geo_fill = (upg_width > UPG_W) ? X_W'(UPG_W) : X_W'(upg_width);
         end
         JOB_MONEY: begin
            geo_x0   = X_W'(MONEY_X0);
            geo_y0   = Y_W'(MONEY_Y0);
            geo_w    = X_W'(BAR_MAX_W);
            geo_h    = Y_W'(BAR_H);
            geo_fill = (money_shift > 16'(BAR_MAX_W)) ? X_W'(BAR_MAX_W)
                                                      : money_shift[X_W-1:0];
         end
         default: ;
      endcase
   end

   rect_scanner u_scanner (
      .clock (clock),
      .reset (reset),
      .start (start),
      .x0    (geo_x0),
      .y0    (geo_y0),
      .w     (geo_w),
      .h     (geo_h),
      .x     (scan_x),
      .y     (scan_y),
      .col   (scan_col),
      .row   (scan_row),
      .valid (scan_valid),
      .last  (scan_last)
   );

   // The fill register is only written at the LOAD edge, so the first pixel
   // takes the live value
   assign fill_use   = (state == ST_LOAD) ? geo_fill : fill_reg;
   assign pix_colour = pixel_colour(job, scan_col, scan_row, geo_w, geo_h, fill_use);

   // Pending flags (set wins over launch clear), operand capture, pixel outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend     <= 4'b0000;
         fill_reg <= '0;
         x        <= '0;
         y        <= '0;
         colour   <= BLACK;
         plot     <= 1'b0;
         done     <= 1'b0;
      end else begin
         pend <= (pend & ~req_clear) | req_set;
         if (state == ST_LOAD) fill_reg <= geo_fill;
         plot <= scan_valid;
         if (scan_valid) begin
            x      <= scan_x;
            y      <= scan_y;
            colour <= pix_colour;
         end
         done <= (state == ST_DONE);
      end
   end

endmodule
`default_nettype wire
